// File: rtl/ddr_params_pkg.sv
// ddr_params_pkg: SDRAM geometry, command encodings and read-engine states
// shared by the init, refresh, write and read engines.
package ddr_params_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 13;
    localparam int BA_WIDTH   = 2;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_BR_T  = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam logic [BA_WIDTH-1:0]   BA_IDLE      = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IDLE    = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PRE_ALL = 13'h0400;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_TRCD,
        RD_READ,
        RD_DATA,
        RD_PRE,
        RD_TRP,
        RD_END
    } rd_state_e;

endpackage

// File: rtl/ddr_ctrl_rd.sv
// ddr_ctrl_rd: SDRAM read engine; ACT/READ/BR_T/PRE sequencing with
// CAS-latency-aligned data capture and per-word ack.
module ddr_ctrl_rd
    import ddr_params_pkg::*;
#(
    parameter int TRCD_CLK = 2,
    parameter int TRP_CLK  = 2,
    parameter int CAS_LAT  = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  init_end_i,
    input  logic                  rd_en_i,
    input  logic [23:0]           rd_addr_i,
    input  logic [9:0]            rd_burst_len_i,
    input  logic [DATA_WIDTH-1:0] rd_sdram_data_i,
    output logic                  rd_ack_o,
    output logic                  rd_end_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [3:0]            rd_cmd_o,
    output logic [BA_WIDTH-1:0]   rd_ba_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o
);

    rd_state_e             state_q, state_d;
    logic [9:0]            cnt_q, cnt_d;
    logic [9:0]            len_q, len_d;
    logic [23:0]           addr_q, addr_d;
    logic [CAS_LAT-1:0]    vld_q, vld_d;
    logic                  ack_q, ack_d;
    logic                  end_q, end_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [BA_WIDTH-1:0]   ba_q, ba_d;
    logic [ADDR_WIDTH-1:0] sa_q, sa_d;
    logic                  accept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   state_d = (rd_en_i && init_end_i) ? RD_ACTIVE : RD_IDLE;
            RD_ACTIVE: state_d = RD_TRCD;
            RD_TRCD:   state_d = (cnt_q == 10'(TRCD_CLK - 1)) ? RD_READ : RD_TRCD;
            RD_READ:   state_d = RD_DATA;
            // stay until the last word has passed the CAS pipeline
            RD_DATA:   state_d = (cnt_q == len_q + 10'(CAS_LAT - 1)) ? RD_PRE : RD_DATA;
            RD_PRE:    state_d = RD_TRP;
            RD_TRP:    state_d = (cnt_q == 10'(TRP_CLK - 1)) ? RD_END : RD_TRP;
            RD_END:    state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
        accept = (state_q == RD_IDLE) && (state_d == RD_ACTIVE);
        cnt_d  = (state_d != state_q || state_q == RD_IDLE) ? '0 : cnt_q + 10'd1;
        addr_d = accept ? rd_addr_i : addr_q;
        len_d  = accept ? ((rd_burst_len_i == '0) ? 10'd1 : rd_burst_len_i) : len_q;
    end

    always_comb begin
        cmd_d = CMD_NOP;
        ba_d  = BA_IDLE;
        sa_d  = ADDR_IDLE;
        case (state_q)
            RD_ACTIVE: begin
                cmd_d = CMD_ACT;
                ba_d  = addr_q[23:22];
                sa_d  = addr_q[21:9];
            end
            RD_READ: begin
                cmd_d = CMD_READ;
                ba_d  = addr_q[23:22];
                sa_d  = {4'b0, addr_q[8:0]};
            end
            RD_DATA:   cmd_d = (cnt_q == len_q - 10'd1) ? CMD_BR_T : CMD_NOP;
            RD_PRE: begin
                cmd_d = CMD_PRE;
                ba_d  = addr_q[23:22];
                sa_d  = ADDR_PRE_ALL;
            end
            default:   cmd_d = CMD_NOP;
        endcase
        // burst-valid flag delayed by CAS_LAT, then one more stage alongside the data capture
        vld_d  = {vld_q[CAS_LAT-2:0], (state_q == RD_DATA) && (cnt_q < len_q)};
        ack_d  = vld_q[CAS_LAT-1];
        data_d = ack_d ? rd_sdram_data_i : '0;
        end_d  = (state_q == RD_END);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RD_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            ack_q   <= 1'b0;
            end_q   <= 1'b0;
            data_q  <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= BA_IDLE;
            sa_q    <= ADDR_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            end_q   <= end_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            sa_q    <= sa_d;
        end
    end

    assign rd_ack_o  = ack_q;
    assign rd_end_o  = end_q;
    assign rd_data_o = data_q;
    assign rd_cmd_o  = cmd_q;
    assign rd_ba_o   = ba_q;
    assign rd_addr_o = sa_q;

endmodule
